gs_mem_cache: RTL and testbench
===============================

GS_MEM_CACHE -- requirements
Module: gs_mem_cache

Interface
REQ-001 SHALL have parameter LINES, default 64, giving the number of direct-mapped 8-byte cache lines (power of 2, 16..256).
REQ-002 SHALL have port clk  in  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports gs_addr in 21 (GS byte address), gs_din in 8 (write data), gs_rd in 1, gs_wr in 1 (level requests held by requester).
REQ-005 SHALL have ports gs_dout out 8 (read data) and gs_wait out 1 (high = request in progress).
REQ-006 SHALL have port cfg_size  in  2  GS memory size: 0=512KB, 1=1MB, 2/3=2MB.
REQ-007 SHALL have port flush  in  1  one-cycle pulse that invalidates all lines.
REQ-008 SHALL have ports mem_addr out 18 (line address = gs_addr[20:3]), mem_rd out 1, mem_wr out 1, mem_be out 8, mem_din out 64.
REQ-009 SHALL have ports mem_dout in 64, mem_valid in 1 (read data strobe) and mem_busy in 1 (DDR bridge cannot accept).

Function
REQ-010 SHALL accept a request on a cycle in IDLE where (gs_rd|gs_wr) is 1 and was 0 in the previous cycle; gs_wr wins if both are set.
REQ-011 SHALL drive gs_wait combinationally high on the accept cycle and in every cycle until state DONE; gs_wait SHALL be low in DONE and IDLE.
REQ-012 SHALL decode the address as offset [2:0], index [log2(LINES)+2:3] and tag as the remaining upper bits; each line holds a valid bit, a tag and 64 data bits.
REQ-013 SHALL treat the address as out of range when cfg_size=0 with gs_addr[20:19]!=0, or when cfg_size=1 with gs_addr[20]=1.
REQ-014 SHALL handle an out-of-range request with no memory access: a read returns 8'hFF, a write is dropped, and the state goes IDLE->DONE.
REQ-015 SHALL, on a read hit, load the selected byte into gs_dout and go IDLE->DONE, which gives gs_wait low one cycle after accept.
REQ-016 SHALL, on a read miss, go to RD_REQ and hold mem_rd=1 until a cycle with mem_busy=0, then go to RD_WAIT with mem_rd=0.
REQ-017 SHALL, in RD_WAIT on mem_valid=1, write mem_dout into the line, set valid, update the tag, load the selected byte into gs_dout and go to DONE.
REQ-018 SHALL write through on every in-range write: go to WR_REQ with mem_din = gs_din replicated 8 times and mem_be one-hot at the offset. It SHALL hold mem_wr=1 until a cycle with mem_busy=0, then go to DONE.
REQ-019 SHALL update the cached byte on a write hit, in the accept cycle, and SHALL NOT allocate a line on a write miss.
REQ-020 SHALL return from DONE to IDLE after exactly one cycle; the new request edge rule of REQ-010 applies from IDLE only.
REQ-021 SHALL ignore mem_valid in any state other than RD_WAIT.
REQ-022 SHALL, on a flush that arrives in IDLE or DONE, clear all valid bits next cycle. A flush that arrives in any other state SHALL be latched and applied on entry to DONE, after the fill of the current read.
REQ-023 SHALL, when flush coincides with a read-hit accept, complete the hit with the pre-flush data.
REQ-024 SHALL keep mem_addr, mem_din and mem_be stable for the whole time mem_rd or mem_wr is high.

Reset
REQ-025 SHALL, with reset_n low, force state IDLE, all valid bits 0, the pending-flush flag 0, gs_dout=8'hFF, mem_rd=0, mem_wr=0, mem_be=0, mem_addr=0 and mem_din=0.
REQ-026 SHALL, after reset asserts mid-transaction, start no memory access and leave no line partially filled; a late mem_valid SHALL be ignored under REQ-021.

Structure
REQ-027 SHALL take the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE) and the address-field widths/constants from shared package gs_mem_pkg.
REQ-028 SHALL place the tag/data storage in one sub-module gs_cache_ram: LINES x (tag+64), one read/write port, byte enables on data.
REQ-029 SHALL keep the valid bits in flops outside gs_cache_ram so that a flush takes a single cycle.

Verification
REQ-030 SHALL verify a cold read: read 0x00123 -> mem_rd with mem_addr=0x00024; return mem_dout=0x8877665544332211 -> gs_dout=0x44, gs_wait low on the DONE cycle.
REQ-031 SHALL verify a hit: re-read 0x00125 -> gs_dout=0x66, no mem_rd, gs_wait high for exactly 1 cycle.
REQ-032 SHALL verify a write hit: write 0xA5 to 0x00121 -> mem_be=8'h02 and mem_din=0xA5A5A5A5A5A5A5A5. A following read of 0x00121 SHALL hit and return 0xA5.
REQ-033 SHALL verify range masking: cfg_size=0, read 0x80000 -> 0xFF with no mem_rd; cfg_size=2, same read -> mem_rd issued.
REQ-034 SHALL verify backpressure and flush: mem_busy held high 5 cycles -> mem_rd held stable for 6 cycles. A flush during RD_WAIT -> the next read of the same line misses.
REQ-035 SHALL verify reset in RD_WAIT: reset_n pulsed, then mem_valid arrives -> ignored, outputs at reset values, and the next read misses.

Source files
------------

// File: rtl/gs_mem_pkg.sv
// Shared definitions for the GS memory cache: controller states, address field widths
// and a byte-lane selector.
package gs_mem_pkg;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d,
                                            input logic [OFF_W-1:0] off);
        return d[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_cache_ram.sv
// Single-port tag/data store for the direct-mapped cache.
// Reads are asynchronous; writes are synchronous with byte enables on the data field.
module gs_cache_ram
    import gs_mem_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned TAG_W = 12
) (
    input  logic                     clk,
    input  logic [$clog2(LINES)-1:0] addr,
    input  logic                     we,
    input  logic                     tag_we,
    input  logic [BE_W-1:0]          be,
    input  logic [TAG_W-1:0]         wtag,
    input  logic [DATA_W-1:0]        wdata,
    output logic [TAG_W-1:0]         rtag,
    output logic [DATA_W-1:0]        rdata
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            if (tag_we) begin
                tag_mem[addr] <= wtag;
            end
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    data_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rtag  = tag_mem[addr];
    assign rdata = data_mem[addr];

endmodule

// File: rtl/gs_mem_cache.sv
// Direct-mapped, write-through byte cache between the GS bus and a 64-bit DDR bridge.
// Valid bits live in flops here so a flush clears every line in one cycle.
module gs_mem_cache
    import gs_mem_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  gs_addr,
    input  logic [7:0]         gs_din,
    input  logic               gs_rd,
    input  logic               gs_wr,
    output logic [7:0]         gs_dout,
    output logic               gs_wait,
    input  logic [1:0]         cfg_size,
    input  logic               flush,
    output logic [LINE_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [BE_W-1:0]    mem_be,
    output logic [DATA_W-1:0]  mem_din,
    input  logic [DATA_W-1:0]  mem_dout,
    input  logic               mem_valid,
    input  logic               mem_busy
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

    state_t           state;
    logic             req_prev;
    logic             flush_pend;
    logic [OFF_W-1:0] off_lat;
    logic [LINES-1:0] valid;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic              ram_tag_we;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [TAG_W-1:0]  ram_rtag;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;
    logic              oor;
    logic              hit;
    logic              fill;

    assign off = gs_addr[OFF_W-1:0];
    assign idx = gs_addr[OFF_W+IDX_W-1:OFF_W];
    assign tag = gs_addr[ADDR_W-1:OFF_W+IDX_W];

    assign accept  = (state == IDLE) && (gs_rd || gs_wr) && !req_prev;
    assign gs_wait = accept || ((state != IDLE) && (state != DONE));
    assign oor     = ((cfg_size == 2'd0) && (gs_addr[20:19] != 2'b00)) ||
                     ((cfg_size == 2'd1) && gs_addr[20]);

    // During a fill the port is steered to the latched line address.
    assign ram_idx = (state == RD_WAIT) ? mem_addr[IDX_W-1:0] : idx;
    assign hit     = valid[idx] && (ram_rtag == tag);
    assign fill    = (state == RD_WAIT) && mem_valid;

    assign ram_we     = fill || (accept && gs_wr && !oor && hit);
    assign ram_tag_we = fill;
    assign ram_be     = fill ? 8'hFF : (8'h01 << off);
    assign ram_wdata  = fill ? mem_dout : {8{gs_din}};

    gs_cache_ram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk    (clk),
        .addr   (ram_idx),
        .we     (ram_we),
        .tag_we (ram_tag_we),
        .be     (ram_be),
        .wtag   (mem_addr[LINE_W-1:IDX_W]),
        .wdata  (ram_wdata),
        .rtag   (ram_rtag),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_prev   <= 1'b0;
            flush_pend <= 1'b0;
            off_lat    <= '0;
            valid      <= '0;
            gs_dout    <= 8'hFF;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_be     <= '0;
            mem_din    <= '0;
        end else begin
            req_prev <= gs_rd || gs_wr;
            if (fill) begin
                valid[mem_addr[IDX_W-1:0]] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end
                    if (accept) begin
                        if (gs_wr) begin
                            if (oor) begin
                                state <= DONE;
                            end else begin
                                state    <= WR_REQ;
                                mem_wr   <= 1'b1;
                                mem_addr <= gs_addr[ADDR_W-1:OFF_W];
                                mem_be   <= 8'h01 << off;
                                mem_din  <= {8{gs_din}};
                            end
                        end else if (oor) begin
                            gs_dout <= 8'hFF;
                            state   <= DONE;
                        end else if (hit) begin
                            gs_dout <= get_byte(ram_rdata, off);
                            state   <= DONE;
                        end else begin
                            state    <= RD_REQ;
                            mem_rd   <= 1'b1;
                            mem_addr <= gs_addr[ADDR_W-1:OFF_W];
                            off_lat  <= off;
                        end
                    end
                end
                RD_REQ: begin
                    if (flush) flush_pend <= 1'b1;
                    if (!mem_busy) begin
                        mem_rd <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_valid) begin
                        gs_dout <= get_byte(mem_dout, off_lat);
                        state   <= DONE;
                    end
                end
                WR_REQ: begin
                    if (flush) flush_pend <= 1'b1;
                    if (!mem_busy) begin
                        mem_wr <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // A deferred flush lands here, after the fill has marked its line valid.
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_mem_cache.sv
// Directed, cycle-exact bench for gs_mem_cache with hand-computed expectations.
module tb_gs_mem_cache;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [20:0] gs_addr;
    logic [7:0]  gs_din;
    logic        gs_rd;
    logic        gs_wr;
    logic [7:0]  gs_dout;
    logic        gs_wait;
    logic [1:0]  cfg_size;
    logic        flush;
    logic [17:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_be;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;
    logic        mem_valid;
    logic        mem_busy;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cycles;

    gs_mem_cache #(
        .LINES (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .gs_addr   (gs_addr),
        .gs_din    (gs_din),
        .gs_rd     (gs_rd),
        .gs_wr     (gs_wr),
        .gs_dout   (gs_dout),
        .gs_wait   (gs_wait),
        .cfg_size  (cfg_size),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_be    (mem_be),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_valid (mem_valid),
        .mem_busy  (mem_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1-2 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [20:0] a, input logic wr, input logic [7:0] d);
        gs_addr = a;
        gs_din  = d;
        gs_wr   = wr;
        gs_rd   = !wr;
        #1;
    endtask

    task automatic gap();
        gs_rd = 1'b0;
        gs_wr = 1'b0;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        gs_addr   = '0;
        gs_din    = '0;
        gs_rd     = 1'b0;
        gs_wr     = 1'b0;
        cfg_size  = 2'd2;
        flush     = 1'b0;
        mem_dout  = '0;
        mem_valid = 1'b0;
        mem_busy  = 1'b0;
        step();
        step();
        check("rst_gs_dout", gs_dout, 8'hFF);
        check("rst_gs_wait", gs_wait, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_be", mem_be, 8'h00);
        check("rst_mem_addr", mem_addr, 18'h0);
        check("rst_mem_din", mem_din, 64'h0);
        reset_n = 1'b1;
        step();

        // Cold read of 0x00123
        request(21'h00123, 1'b0, 8'h00);
        check("cold_accept_wait", gs_wait, 1'b1);
        step();
        check("cold_mem_rd", mem_rd, 1'b1);
        check("cold_mem_addr", mem_addr, 18'h00024);
        step();
        check("cold_rdwait_rd", mem_rd, 1'b0);
        mem_dout  = 64'h8877665544332211;
        mem_valid = 1'b1;
        #1;
        check("cold_rdwait_wait", gs_wait, 1'b1);
        step();
        mem_valid = 1'b0;
        check("cold_dout", gs_dout, 8'h44);
        check("cold_done_wait", gs_wait, 1'b0);
        gap();

        // Hit on the same line
        request(21'h00125, 1'b0, 8'h00);
        check("hit_accept_wait", gs_wait, 1'b1);
        step();
        check("hit_dout", gs_dout, 8'h66);
        check("hit_no_rd", mem_rd, 1'b0);
        check("hit_done_wait", gs_wait, 1'b0);
        gap();

        // Write hit, write-through
        request(21'h00121, 1'b1, 8'hA5);
        check("wr_accept_wait", gs_wait, 1'b1);
        step();
        check("wr_mem_wr", mem_wr, 1'b1);
        check("wr_mem_be", mem_be, 8'h02);
        check("wr_mem_din", mem_din, 64'hA5A5A5A5A5A5A5A5);
        check("wr_mem_addr", mem_addr, 18'h00024);
        step();
        check("wr_done_mem_wr", mem_wr, 1'b0);
        check("wr_done_wait", gs_wait, 1'b0);
        gap();
        request(21'h00121, 1'b0, 8'h00);
        step();
        check("wr_hit_dout", gs_dout, 8'hA5);
        check("wr_hit_no_rd", mem_rd, 1'b0);
        gap();
        request(21'h00123, 1'b0, 8'h00);
        step();
        check("wr_other_byte", gs_dout, 8'h44);
        gap();

        // Range masking
        cfg_size = 2'd0;
        request(21'h80000, 1'b0, 8'h00);
        step();
        check("oor512_dout", gs_dout, 8'hFF);
        check("oor512_no_rd", mem_rd, 1'b0);
        check("oor512_wait", gs_wait, 1'b0);
        gap();
        cfg_size = 2'd1;
        request(21'h100000, 1'b0, 8'h00);
        step();
        check("oor1m_no_rd", mem_rd, 1'b0);
        gap();
        cfg_size = 2'd2;
        request(21'h80000, 1'b0, 8'h00);
        step();
        check("in2m_mem_rd", mem_rd, 1'b1);
        check("in2m_mem_addr", mem_addr, 18'h10000);
        step();
        mem_dout  = 64'h0123456789ABCDEF;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("in2m_dout", gs_dout, 8'hEF);
        gap();

        // Backpressure: busy for 5 cycles holds the read request 6 cycles
        mem_busy = 1'b1;
        rd_cycles = 0;
        request(21'h00200, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            if (mem_rd) rd_cycles++;
            check("bp_addr_stable", mem_addr, 18'h00040);
            step();
        end
        mem_busy = 1'b0;
        if (mem_rd) rd_cycles++;
        step();
        check("bp_rd_cycles", rd_cycles, 6);
        check("bp_rd_dropped", mem_rd, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("bp_still_waiting", gs_wait, 1'b1);
        mem_dout  = 64'hDEADBEEFCAFEF00D;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("bp_dout", gs_dout, 8'h0D);
        gap();
        request(21'h00200, 1'b0, 8'h00);
        step();
        check("flush_then_miss", mem_rd, 1'b1);
        step();
        mem_dout  = 64'h1122334455667788;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("refill_dout", gs_dout, 8'h88);
        gap();

        // Reset while waiting for fill data
        request(21'h00300, 1'b0, 8'h00);
        step();
        step();
        check("rst_case_rdwait", gs_wait, 1'b1);
        reset_n = 1'b0;
        gs_rd   = 1'b0;
        #1;
        check("rst_async_dout", gs_dout, 8'hFF);
        check("rst_async_addr", mem_addr, 18'h0);
        step();
        reset_n = 1'b1;
        mem_dout  = 64'h5555555555555555;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("late_valid_dout", gs_dout, 8'hFF);
        check("late_valid_wait", gs_wait, 1'b0);
        check("late_valid_rd", mem_rd, 1'b0);
        step();
        request(21'h00300, 1'b0, 8'h00);
        step();
        check("post_rst_miss", mem_rd, 1'b1);
        step();
        mem_dout  = 64'h0F0E0D0C0B0A0908;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("post_rst_fill", gs_dout, 8'h08);
        gap();

        // Flush coinciding with a read-hit accept
        request(21'h00302, 1'b0, 8'h00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_hit_dout", gs_dout, 8'h0A);
        check("flush_hit_no_rd", mem_rd, 1'b0);
        gap();
        request(21'h00302, 1'b0, 8'h00);
        step();
        check("flush_hit_next_miss", mem_rd, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
